iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, operand/result width (power of two, >= 8).
REQ-002 The block SHALL expose port clk  input  1  sole clock, all state on rising edge.
REQ-003 The block SHALL expose port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL expose port flush  input  1  synchronous abort of any in-flight operation.
REQ-005 The block SHALL expose port in_valid  input  1  operation request.
REQ-006 The block SHALL expose port in_ready  output  1  request accepted when in_valid & in_ready.
REQ-007 The block SHALL expose ports ALUOp  input  2, opb5  input  1, funct3  input  3, funct7b5  input  1, funct7b0  input  1  RV32 decode fields.
REQ-008 The block SHALL expose ports src_a, src_b  input  XLEN  operands.
REQ-009 The block SHALL expose port out_valid  output  1  result available; out_ready  input  1  result consumed.
REQ-010 The block SHALL expose port result  output  XLEN  registered result; ctrl_dbg  output  5  decoded control of held op.

Function
- REQ-011 Decode SHALL be: ALUOp 0 -> ADD; 1 -> SUB; 2 -> funct3/funct7b5/opb5 table per RV32I (register form: funct7b5 selects SUB/SRA; immediate form: funct7b5 only selects SRA); 3 -> ADD.
- REQ-012 Base control codes SHALL be ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLL 6, SRL 7, SRA 8, SLTU 9; M codes MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17.
- REQ-013 States SHALL be IDLE, BUSY, DONE; in_ready SHALL equal (state == IDLE).
- REQ-014 IDLE + accept of a base op SHALL compute and register result, go to DONE; out_valid asserts the cycle after accept (latency 1).
- REQ-015 IDLE + accept of an M op SHALL load operands, go to BUSY, iterate one bit per cycle for exactly XLEN cycles, then DONE; out_valid asserts XLEN+1 cycles after accept.
- REQ-016 DONE SHALL hold out_valid, result, ctrl_dbg stable until out_valid & out_ready, then return to IDLE next cycle.
- REQ-017 Shifts SHALL use src_b[log2(XLEN)-1:0]; SLT/SLTU results zero-extended to XLEN.
- REQ-018 MUL SHALL return low XLEN bits of 2*XLEN product; MULH/MULHSU/MULHU the high XLEN bits with signed/signed-unsigned/unsigned operands.
- REQ-019 Divide by zero SHALL give quotient all-ones, remainder = src_a; signed overflow (most-negative / -1) SHALL give quotient = src_a, remainder 0, both still taking XLEN cycles.
- REQ-020 flush SHALL return state to IDLE next cycle from any state, deassert out_valid, discard result; flush with in_valid SHALL not accept.
- REQ-021 Unused decode combinations SHALL map to ADD.

Reset
- REQ-022 reset SHALL force IDLE, out_valid 0, result 0, ctrl_dbg 0, iteration counter 0 immediately, independent of clk.
- REQ-023 reset mid-BUSY SHALL discard the operation; first accept after deassertion behaves as from power-up.

Configuration
- REQ-024 Macro ITER_ALU_M_EXT_EN defined: funct7b0=1 with ALUOp 2, opb5 1 selects M codes by funct3 (0..7 -> 10..17).
- REQ-025 Macro undefined: funct7b0 ignored, no multiply/divide datapath, BUSY unreachable, every op latency 1.

Structure
- REQ-026 Control codes, state encoding and ALUOp values SHALL live in shared package alu_pkg.
- REQ-027 The iterative multiply/divide datapath SHALL be sub-module iter_muldiv (start, done, op, operands, result), instantiated only under ITER_ALU_M_EXT_EN.

Verification
- REQ-028 ALUOp 2, opb5 1, funct3 0, funct7b5 1, a=5, b=7 -> out_valid 1 cycle later, result 0xFFFFFFFE, ctrl_dbg 1.
- REQ-029 funct3 5, funct7b5 1, opb5 0, a=0x80000000, b=0x24 -> result 0xF8000000 (shift by 4).
- REQ-030 (M_EXT) DIV a=0x80000000, b=0xFFFFFFFF -> out_valid at cycle 33, result 0x80000000; DIVU b=0 -> 0xFFFFFFFF.
- REQ-031 (M_EXT) MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE; out_ready held 0 for 5 cycles -> result stable, in_ready 0.
- REQ-032 flush at BUSY cycle 10 -> IDLE next cycle, out_valid never asserts; reset asserted mid-BUSY -> outputs 0 same cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for iter_alu.
//   ctrl_e  - 5-bit decoded control codes (base ops 0..9, M-extension ops 10..17)
//   state_e - iter_alu sequencer states
//   ALUOP_* - ALUOp field encodings
//   decode  - ALUOp/funct3/funct7b5/opb5 -> base control code (RV32I table);
//             the M-extension override is applied in iter_alu under ITER_ALU_M_EXT_EN.
package alu_pkg;

  typedef enum logic [4:0] {
    C_ADD = 5'd0, C_SUB, C_AND, C_OR, C_XOR, C_SLT, C_SLL, C_SRL, C_SRA, C_SLTU,
    C_MUL, C_MULH, C_MULHSU, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU
  } ctrl_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_ADD3  = 2'd3;

  // opb5 = 1 is the register form: there funct7b5 picks SUB over ADD.
  // In the immediate form funct7b5 is part of the immediate except for shifts.
  function automatic ctrl_e decode(input logic [1:0] aluop, input logic opb5,
                                   input logic [2:0] funct3, input logic funct7b5);
    ctrl_e c;
    c = C_ADD;
    case (aluop)
      ALUOP_SUB: c = C_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'd0:    c = (opb5 && funct7b5) ? C_SUB : C_ADD;
          3'd1:    c = C_SLL;
          3'd2:    c = C_SLT;
          3'd3:    c = C_SLTU;
          3'd4:    c = C_XOR;
          3'd5:    c = funct7b5 ? C_SRA : C_SRL;
          3'd6:    c = C_OR;
          default: c = C_AND;
        endcase
      end
      default: c = C_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: bit-serial multiply / restoring divide, one bit per cycle.
//   clk, reset     - clock, async active-high reset
//   start          - load operands and op (top is accepting an M op)
//   op             - C_MUL..C_REMU
//   a, b           - operands
//   done           - high in the cycle whose rising edge performs the last iteration
//   result         - final value, held stable once all XLEN iterations are done
// Works on operand magnitudes and applies signs at the output.
module iter_muldiv import alu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  ctrl_e           op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;

  ctrl_e             op_q;
  logic              busy, neg_q, neg_r, dz;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   mq, rem, a_q;
  logic              sa, sb, is_div;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     sh, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd;

  always_comb begin
    is_div = (op >= C_DIV);
    sa     = a[XLEN-1] && (op == C_MULH || op == C_MULHSU || op == C_DIV || op == C_REM);
    sb     = b[XLEN-1] && (op == C_MULH || op == C_DIV || op == C_REM);
    abs_a  = sa ? -a : a;
    abs_b  = sb ? -b : b;
    // restoring step: shift next dividend bit into the partial remainder, trial subtract
    sh     = {rem, mq[XLEN-1]};
    diff   = sh - {1'b0, mcand[XLEN-1:0]};
  end

  assign done = busy && (cnt == CW'(XLEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= C_ADD;
      busy  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      mq    <= '0;
      rem   <= '0;
      a_q   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else if (start) begin
      op_q  <= op;
      busy  <= 1'b1;
      cnt   <= '0;
      acc   <= '0;
      mcand <= {{XLEN{1'b0}}, is_div ? abs_b : abs_a};
      mq    <= is_div ? abs_a : abs_b;
      rem   <= '0;
      a_q   <= a;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      dz    <= (b == '0);
    end else if (busy && cnt != CW'(XLEN)) begin
      cnt <= cnt + 1'b1;
      if (op_q >= C_DIV) begin
        if (!diff[XLEN]) begin
          rem <= diff[XLEN-1:0];
          mq  <= {mq[XLEN-2:0], 1'b1};
        end else begin
          rem <= sh[XLEN-1:0];
          mq  <= {mq[XLEN-2:0], 1'b0};
        end
      end else begin
        if (mq[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        mq    <= mq >> 1;
      end
    end
  end

  // Divide by zero falls out of the restoring loop as all-ones / |a|, but the
  // sign fix would corrupt it for signed ops, so it is overridden here.
  // Most-negative / -1 needs no special case: |a| / 1 negated twice is a.
  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -mq : mq;
    rmd  = neg_r ? -rem : rem;
    case (op_q)
      C_MULH, C_MULHSU, C_MULHU: result = prod[2*XLEN-1:XLEN];
      C_DIV, C_DIVU:             result = dz ? '1 : quo;
      C_REM, C_REMU:             result = dz ? a_q : rmd;
      default:                   result = prod[XLEN-1:0];
    endcase
  end

endmodule

// File: rtl/iter_alu.sv
// iter_alu: RV32 ALU with a valid/ready handshake. Base ops finish in one
// cycle; with ITER_ALU_M_EXT_EN defined, M ops run on iter_muldiv for XLEN cycles.
//   clk, reset          - clock, async active-high reset
//   flush               - synchronous abort, back to IDLE, result discarded
//   in_valid/in_ready   - request handshake (in_ready = IDLE)
//   ALUOp, opb5, funct3, funct7b5, funct7b0 - decode fields
//   src_a, src_b        - operands
//   out_valid/out_ready - result handshake, result/ctrl_dbg held while waiting
//   result, ctrl_dbg    - result and decoded control of the held op
module iter_alu import alu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic            opb5,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      ctrl_dbg
);
  localparam int SHW = $clog2(XLEN);

  state_e          state, state_nx;
  ctrl_e           ctrl_dec, ctrl_q;
  logic [XLEN-1:0] base_res, res_q;
  logic [SHW-1:0]  shamt;
  logic            is_m, md_start, md_done, load_base;

  always_comb begin
    ctrl_dec = decode(ALUOp, opb5, funct3, funct7b5);
`ifdef ITER_ALU_M_EXT_EN
    if (ALUOp == ALUOP_FUNCT && opb5 && funct7b0)
      ctrl_dec = ctrl_e'(5'd10 + {2'b00, funct3});
    is_m = (ctrl_dec >= C_MUL);
`else
    is_m = 1'b0;
`endif
  end

  assign shamt = src_b[SHW-1:0];

  always_comb begin
    case (ctrl_dec)
      C_SUB:   base_res = src_a - src_b;
      C_AND:   base_res = src_a & src_b;
      C_OR:    base_res = src_a | src_b;
      C_XOR:   base_res = src_a ^ src_b;
      C_SLT:   base_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      C_SLTU:  base_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      C_SLL:   base_res = src_a << shamt;
      C_SRL:   base_res = src_a >> shamt;
      C_SRA:   base_res = XLEN'($signed(src_a) >>> shamt);
      default: base_res = src_a + src_b;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    md_start  = 1'b0;
    load_base = 1'b0;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          if (is_m) begin
            state_nx = S_BUSY;
            md_start = 1'b1;
          end else begin
            state_nx  = S_DONE;
            load_base = 1'b1;
          end
        end
        S_BUSY:  if (md_done) state_nx = S_DONE;
        S_DONE:  if (out_ready) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q  <= '0;
      ctrl_q <= C_ADD;
    end else begin
      if (load_base) res_q <= base_res;
      if (load_base || md_start) ctrl_q <= ctrl_dec;
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign ctrl_dbg  = ctrl_q;

`ifdef ITER_ALU_M_EXT_EN
  logic [XLEN-1:0] md_res;

  iter_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .op     (ctrl_dec),
    .a      (src_a),
    .b      (src_b),
    .done   (md_done),
    .result (md_res)
  );

  // The multiplier/divider stops after its last iteration, so its output is
  // already stable in DONE and is presented directly for M ops.
  assign result = (ctrl_q >= C_MUL) ? md_res : res_q;
`else
  logic unused_ok;
  assign md_done   = 1'b0;
  assign unused_ok = funct7b0 | md_start;
  assign result    = res_q;
`endif

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: scoreboard bench for iter_alu (XLEN = 32). Expected results are
// computed by a 64-bit reference model and queued at accept time; they are
// popped when out_valid rises. M-extension cases run when ITER_ALU_M_EXT_EN is defined.
module tb_iter_alu;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, opb5, funct7b5, funct7b0;
  logic        out_valid, out_ready;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic [31:0] src_a, src_b, result;
  logic [4:0]  ctrl_dbg;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  ctrl;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  iter_alu dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .opb5(opb5), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ctrl_dbg(ctrl_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_ctrl(input logic [1:0] op, input logic ob5,
                                          input logic [2:0] f3, input logic f7b5, input logic f7b0);
    if (op == 2'd1) return 5'd1;
    if (op != 2'd2) return 5'd0;
`ifdef ITER_ALU_M_EXT_EN
    if (ob5 && f7b0) return 5'd10 + {2'b00, f3};
`endif
    case (f3)
      3'd0:    return (ob5 && f7b5) ? 5'd1 : 5'd0;
      3'd1:    return 5'd6;
      3'd2:    return 5'd5;
      3'd3:    return 5'd9;
      3'd4:    return 5'd4;
      3'd5:    return f7b5 ? 5'd8 : 5'd7;
      3'd6:    return 5'd3;
      default: return 5'd2;
    endcase
  endfunction

  function automatic logic [31:0] ref_res(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb2;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    case (c)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return {31'b0, $signed(a) < $signed(b)};
      5'd6:  return a << b[4:0];
      5'd7:  return a >> b[4:0];
      5'd8:  return 32'($signed(a) >>> b[4:0]);
      5'd9:  return {31'b0, a < b};
      5'd10: begin p = 64'(sa * sb2); return p[31:0]; end
      5'd11: begin p = 64'(sa * sb2); return p[63:32]; end
      5'd12: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
      5'd13: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      5'd14: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb2);
      end
      5'd15: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb2);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic drive(input logic [1:0] op, input logic ob5, input logic [2:0] f3,
                       input logic f7b5, input logic f7b0, input logic [31:0] a, input logic [31:0] b);
    ALUOp = op; opb5 = ob5; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0;
    src_a = a; src_b = b; in_valid = 1'b1;
  endtask

  // One full transaction: accept, wait for out_valid, optionally stall, consume.
  task automatic run_op(input string tag, input logic [1:0] op, input logic ob5, input logic [2:0] f3,
                        input logic f7b5, input logic f7b0, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [4:0] ec, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    drive(op, ob5, f3, f7b5, f7b0, a, b);
    chk({tag, "_inrdy"}, {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.res = er; e.ctrl = ec; e.lat = (ec >= 5'd10) ? 33 : 1;
    sb.push_back(e);
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, 64'(n), 64'(e.lat));
    chk({tag, "_res"}, {32'b0, result}, {32'b0, e.res});
    chk({tag, "_ctrl"}, {59'b0, ctrl_dbg}, {59'b0, e.ctrl});
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_res"}, {32'b0, result}, {32'b0, e.res});
      chk({tag, "_hold_vld"}, {63'b0, out_valid}, 64'd1);
      chk({tag, "_hold_rdy"}, {63'b0, in_ready}, 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_rel_vld"}, {63'b0, out_valid}, 64'd0);
    chk({tag, "_rel_rdy"}, {63'b0, in_ready}, 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"}, {63'b0, out_valid}, 64'd0);
    chk({tag, "_res"}, {32'b0, result}, 64'd0);
    chk({tag, "_ctrl"}, {59'b0, ctrl_dbg}, 64'd0);
    chk({tag, "_rdy"}, {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [2:0]  f3;
    logic        f7b5, ob5, seen;
    logic [4:0]  c;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ALUOp = 2'd0; opb5 = 1'b0; funct3 = 3'd0; funct7b5 = 1'b0; funct7b0 = 1'b0;
    src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    chk_zero("por");
    reset = 1'b0;

    // directed decode / datapath cases
    run_op("sub_r",  2'd2, 1'b1, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 5'd1, 0);
    run_op("sra_i",  2'd2, 1'b0, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'h24, 32'hF800_0000, 5'd8, 0);
    run_op("add_op0", 2'd0, 1'b1, 3'd4, 1'b1, 1'b0, 32'h1234, 32'h1111, 32'h2345, 5'd0, 0);
    run_op("sub_op1", 2'd1, 1'b0, 3'd7, 1'b0, 1'b0, 32'd3, 32'd10, 32'hFFFF_FFF9, 5'd1, 0);
    run_op("add_op3", 2'd3, 1'b1, 3'd5, 1'b1, 1'b1, 32'd40, 32'd2, 32'd42, 5'd0, 0);
    run_op("addi_f7", 2'd2, 1'b0, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7, 32'd12, 5'd0, 0);
    run_op("sll_msk", 2'd2, 1'b1, 3'd1, 1'b0, 1'b0, 32'h0000_0003, 32'h21, 32'h6, 5'd6, 0);
    run_op("srl",    2'd2, 1'b1, 3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'h1F, 32'h1, 5'd7, 0);
    run_op("slt_neg", 2'd2, 1'b1, 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 5'd5, 0);
    run_op("sltu",   2'd2, 1'b1, 3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd9, 0);
    run_op("and_hold", 2'd2, 1'b1, 3'd7, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 5'd2, 3);

    for (int i = 0; i < 16; i++) begin
      f3 = 3'($urandom_range(0, 7)); f7b5 = 1'($urandom_range(0, 1)); ob5 = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      c = ref_ctrl(2'd2, ob5, f3, f7b5, 1'b0);
      run_op("rnd", 2'd2, ob5, f3, f7b5, 1'b0, a, b, ref_res(c, a, b), c, 0);
    end

`ifdef ITER_ALU_M_EXT_EN
    run_op("div_ovf", 2'd2, 1'b1, 3'd4, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd14, 0);
    run_op("divu_z",  2'd2, 1'b1, 3'd5, 1'b0, 1'b1, 32'd1234, 32'd0, 32'hFFFF_FFFF, 5'd15, 0);
    run_op("rem_z",   2'd2, 1'b1, 3'd6, 1'b0, 1'b1, 32'hFFFF_FF85, 32'd0, 32'hFFFF_FF85, 5'd16, 0);
    run_op("rem_ovf", 2'd2, 1'b1, 3'd6, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd16, 0);
    run_op("mulhu",   2'd2, 1'b1, 3'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd13, 5);
    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; b = (i == 3) ? 32'd0 : $urandom;
      if (i[0]) b = b >> $urandom_range(0, 31);
      c = 5'd10 + {2'b00, f3};
      run_op("rnd_m", 2'd2, 1'b1, f3, 1'b0, 1'b1, a, b, ref_res(c, a, b), c, 0);
    end

    // flush during BUSY: the op must vanish
    @(negedge clk);
    drive(2'd2, 1'b1, 3'd4, 1'b0, 1'b1, 32'd100, 32'd7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_rdy", {63'b0, in_ready}, 64'd1);
    chk("flush_busy_vld", {63'b0, out_valid}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_busy_never", {63'b0, seen}, 64'd0);

    // async reset during BUSY
    @(negedge clk);
    drive(2'd2, 1'b1, 3'd0, 1'b0, 1'b1, 32'd9, 32'd9);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_zero("rst_busy");
    @(negedge clk);
    reset = 1'b0;
    run_op("mul_after", 2'd2, 1'b1, 3'd0, 1'b0, 1'b1, 32'd9, 32'hFFFF_FFFD, 32'hFFFF_FFE5, 5'd10, 0);
`else
    // without the M extension funct7b0 is ignored: plain ADD with latency 1
    run_op("m_off", 2'd2, 1'b1, 3'd0, 1'b0, 1'b1, 32'd6, 32'd7, 32'd13, 5'd0, 0);
    run_op("m_off_x", 2'd2, 1'b1, 3'd4, 1'b0, 1'b1, 32'hFF, 32'h0F, 32'hF0, 5'd4, 0);
`endif

    // flush while holding a result in DONE
    @(negedge clk);
    drive(2'd2, 1'b1, 3'd6, 1'b0, 1'b0, 32'h10, 32'h01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("flush_done_pre", {63'b0, out_valid}, 64'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_done_vld", {63'b0, out_valid}, 64'd0);
    chk("flush_done_rdy", {63'b0, in_ready}, 64'd1);

    // flush together with in_valid must not accept
    @(negedge clk);
    drive(2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd1, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_acc_vld", {63'b0, out_valid}, 64'd0);
    chk("flush_acc_rdy", {63'b0, in_ready}, 64'd1);

    // async reset while a result is held
    @(negedge clk);
    drive(2'd2, 1'b1, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_done_pre", {32'b0, result}, 64'hFFFF_FFFE);
    #2 reset = 1'b1;
    #1 chk_zero("rst_done");
    @(negedge clk);
    reset = 1'b0;
    run_op("sub_again", 2'd2, 1'b1, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 5'd1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
